// File: rtl/vga_pkg.sv
// Shared encodings for the VGA pattern source: display modes, RGB 3:3:2 pixel type,
// named colours and the colour-bar lookup.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    localparam rgb332_t RGB_WHITE   = 8'hFF;
    localparam rgb332_t RGB_YELLOW  = 8'hFC;
    localparam rgb332_t RGB_CYAN    = 8'h1F;
    localparam rgb332_t RGB_GREEN   = 8'h1C;
    localparam rgb332_t RGB_MAGENTA = 8'hE3;
    localparam rgb332_t RGB_RED     = 8'hE0;
    localparam rgb332_t RGB_BLUE    = 8'h03;
    localparam rgb332_t RGB_BLACK   = 8'h00;

    function automatic rgb332_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/sprite_mover.sv
// One axis of the bouncing box: position plus direction, stepped once per frame,
// clamped to [0, LIMIT-SIZE] and reflected at either edge.
module sprite_mover #(
    parameter int LIMIT = 640,
    parameter int SIZE  = 32,
    parameter int STEP  = 2,
    parameter int W     = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         advance,
    output logic [W-1:0] pos
);
    localparam int MAXP = LIMIT - SIZE;

    logic dir_neg;

    always_ff @(posedge clock) begin
        if (reset) begin
            pos     <= '0;
            dir_neg <= 1'b0;
        end else if (advance) begin
            if (!dir_neg) begin
                if (int'(pos) + STEP >= MAXP) begin
                    pos     <= W'(MAXP);
                    dir_neg <= 1'b1;
                end else begin
                    pos <= pos + W'(STEP);
                end
            end else begin
                if (int'(pos) <= STEP) begin
                    pos     <= '0;
                    dir_neg <= 1'b0;
                end else begin
                    pos <= pos - W'(STEP);
                end
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: registered RGB 3:3:2 from raster counters, with modes switched
// only at frame start. Define BOUNCE_BOX_EN to add the white bouncing-box overlay.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CNT_W      = 10,
    parameter int NUM_BARS   = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int GRAD_SHIFT = 6,
    parameter int BOX_SIZE   = 32,
    parameter int BOX_STEP   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] hcount,
    input  logic [CNT_W-1:0] vcount,
    input  logic [1:0]       mode_sel,
    input  logic [7:0]       solid_rgb,
    output logic [2:0]       red,
    output logic [2:0]       green,
    output logic [1:0]       blue,
    output logic [1:0]       mode_active,
    output logic [7:0]       frame_cnt
);
    localparam int BAR_W = H_ACTIVE / NUM_BARS;

    mode_t            mode_q;
    rgb332_t          pix, pix_q;
    logic             frame_start, in_active;
    logic [CNT_W-1:0] bar_raw, bar_idx;

    assign frame_start = enable && (hcount == '0) && (vcount == '0);
    assign in_active   = (int'(hcount) < H_ACTIVE) && (int'(vcount) < V_ACTIVE);

    // Last bar absorbs any remainder pixels when H_ACTIVE is not a multiple of NUM_BARS.
    assign bar_raw = hcount / CNT_W'(BAR_W);
    assign bar_idx = (int'(bar_raw) > NUM_BARS - 1) ? CNT_W'(NUM_BARS - 1) : bar_raw;

`ifdef BOUNCE_BOX_EN
    logic [CNT_W-1:0] box_x, box_y;
    logic             in_box;

    sprite_mover #(.LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP), .W(CNT_W)) u_box_x (
        .clock(clock), .reset(reset), .advance(frame_start), .pos(box_x)
    );
    sprite_mover #(.LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP), .W(CNT_W)) u_box_y (
        .clock(clock), .reset(reset), .advance(frame_start), .pos(box_y)
    );

    assign in_box = (hcount >= box_x) && (int'(hcount) < int'(box_x) + BOX_SIZE) &&
                    (vcount >= box_y) && (int'(vcount) < int'(box_y) + BOX_SIZE);
`endif

    always_comb begin
        pix = RGB_BLACK;
        unique case (mode_q)
            MODE_BARS:     pix = bar_color(bar_idx[2:0]);
            MODE_CHECKER:  pix = (hcount[CHECK_LOG2] ^ vcount[CHECK_LOG2]) ? RGB_WHITE : RGB_BLACK;
            MODE_GRADIENT: pix = {hcount[GRAD_SHIFT+2:GRAD_SHIFT], vcount[GRAD_SHIFT+2:GRAD_SHIFT],
                                  frame_cnt[1:0]};
            MODE_SOLID:    pix = solid_rgb;
        endcase
`ifdef BOUNCE_BOX_EN
        if (in_box) pix = RGB_WHITE;
`endif
        if (!in_active) pix = RGB_BLACK;
    end

    // Mode and frame counter update alongside the frame-start pixel, which still uses the old state.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_q     <= RGB_BLACK;
            mode_q    <= MODE_BARS;
            frame_cnt <= 8'd0;
        end else if (enable) begin
            pix_q <= pix;
            if (frame_start) begin
                mode_q    <= mode_t'(mode_sel);
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign red         = pix_q.r;
    assign green       = pix_q.g;
    assign blue        = pix_q.b;
    assign mode_active = mode_q;

endmodule
